// File: rtl/ff_fifo_pkg.sv
// Shared widths, pointer wrap helper and flag bundle for the registered-flag FIFO family.
package ff_fifo_pkg;

   function automatic int ptr_w(input int depth);
      return (depth > 32'sd1) ? $clog2(depth) : 32'sd1;
   endfunction

   function automatic int cnt_w(input int depth);
      return $clog2(depth + 32'sd1);
   endfunction

   // Explicit wrap at depth-1 so non-power-of-2 depths never index past the array.
   function automatic int unsigned next_ptr(input int unsigned ptr, input int unsigned depth);
      int unsigned nxt_s;
      if (ptr == depth - 32'd1) begin
         nxt_s = 32'd0;
      end else begin
         nxt_s = ptr + 32'd1;
      end
      return nxt_s;
   endfunction

   typedef struct packed {
      logic empty;
      logic full;
      logic almost_empty;
      logic almost_full;
   } fifo_flags_t;

endpackage

// File: rtl/ff_fifo_ptr_wrap.sv
// Circular pointer register with enable; wraps from depth-1 to 0 for any depth >= 2.
module ff_fifo_ptr_wrap
   import ff_fifo_pkg::*;
#(
   parameter int depth = 10
) (
   input  logic                      clk,
   input  logic                      rst_n,
   input  logic                      en,
   output logic [ptr_w(depth)-1:0]   ptr
);

   localparam int pw = ptr_w(depth);

   logic [pw-1:0] ptr_r;

   // pointer state: hold, or advance with explicit wrap
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         ptr_r <= '0;
      end else if (en) begin
         ptr_r <= pw'(next_ptr(32'(ptr_r), depth));
      end else begin
         ptr_r <= ptr_r;
      end
   end

   assign ptr = ptr_r;

endmodule

// File: rtl/ff_fifo_with_reg_flags_and_count.sv
// Synchronous FIFO with guarded push/pop, registered count and registered threshold flags.
// Optional sticky overflow/underflow ports are enabled by defining FIFO_ERR_FLAGS_EN.
module ff_fifo_with_reg_flags_and_count
   import ff_fifo_pkg::*;
#(
   parameter int width            = 8,
   parameter int depth            = 10,
   parameter int almost_full_lvl  = 8,
   parameter int almost_empty_lvl = 2
) (
   input  logic                      clk,
   input  logic                      rst_n,
   input  logic                      push,
   input  logic                      pop,
   input  logic [width-1:0]          write_data,
   output logic [width-1:0]          read_data,
   output logic                      empty,
   output logic                      full,
   output logic                      almost_empty,
   output logic                      almost_full,
`ifdef FIFO_ERR_FLAGS_EN
   output logic                      overflow,
   output logic                      underflow,
`endif
   output logic [cnt_w(depth)-1:0]   count
);

   localparam int pw = ptr_w(depth);
   localparam int cw = cnt_w(depth);

   localparam logic [cw-1:0] depth_c = cw'(depth);
   localparam logic [cw-1:0] af_c    = cw'(almost_full_lvl);
   localparam logic [cw-1:0] ae_c    = cw'(almost_empty_lvl);
   localparam logic [cw-1:0] one_c   = cw'(32'd1);

   localparam fifo_flags_t flags_rst_c = '{
      empty:        1'b1,
      full:         1'b0,
      almost_empty: 1'b1,
      almost_full:  (almost_full_lvl == 32'sd0)
   };

   logic              push_ok_s;
   logic              pop_ok_s;
   logic [pw-1:0]     wr_ptr_s;
   logic [pw-1:0]     rd_ptr_s;
   logic [cw-1:0]     count_r;
   logic [cw-1:0]     count_d_s;
   fifo_flags_t       flags_r;
   fifo_flags_t       flags_d_s;
   logic [width-1:0]  mem_r [depth];

   // accept guards: a push into a full FIFO rides on a simultaneous pop
   always_comb begin
      push_ok_s = push & (~flags_r.full | pop);
      pop_ok_s  = pop & ~flags_r.empty;
   end

   ff_fifo_ptr_wrap #(.depth(depth)) u_wr_ptr (
      .clk   (clk),
      .rst_n (rst_n),
      .en    (push_ok_s),
      .ptr   (wr_ptr_s)
   );

   ff_fifo_ptr_wrap #(.depth(depth)) u_rd_ptr (
      .clk   (clk),
      .rst_n (rst_n),
      .en    (pop_ok_s),
      .ptr   (rd_ptr_s)
   );

   // storage write; contents are intentionally not reset
   always_ff @(posedge clk) begin
      if (push_ok_s) begin
         mem_r[wr_ptr_s] <= write_data;
      end else begin
         mem_r[wr_ptr_s] <= mem_r[wr_ptr_s];
      end
   end

   assign read_data = mem_r[rd_ptr_s];

   // next occupancy and the flags derived from it
   always_comb begin
      count_d_s = count_r;
      case ({push_ok_s, pop_ok_s})
         2'b10:   count_d_s = count_r + one_c;
         2'b01:   count_d_s = count_r - one_c;
         default: count_d_s = count_r;
      endcase
      flags_d_s.empty        = (count_d_s == '0);
      flags_d_s.full         = (count_d_s == depth_c);
      flags_d_s.almost_empty = (count_d_s <= ae_c);
      flags_d_s.almost_full  = (count_d_s >= af_c);
   end

   // count and flags update together on the same edge
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         count_r <= '0;
         flags_r <= flags_rst_c;
      end else begin
         count_r <= count_d_s;
         flags_r <= flags_d_s;
      end
   end

   assign count        = count_r;
   assign empty        = flags_r.empty;
   assign full         = flags_r.full;
   assign almost_empty = flags_r.almost_empty;
   assign almost_full  = flags_r.almost_full;

`ifdef FIFO_ERR_FLAGS_EN
   logic overflow_r;
   logic underflow_r;

   // sticky records of rejected requests, cleared only by rst_n
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         overflow_r  <= 1'b0;
         underflow_r <= 1'b0;
      end else begin
         overflow_r  <= overflow_r  | (push & ~push_ok_s);
         underflow_r <= underflow_r | (pop & ~pop_ok_s);
      end
   end

   assign overflow  = overflow_r;
   assign underflow = underflow_r;
`endif

endmodule

// File: tb/tb_ff_fifo_with_reg_flags_and_count.sv
// Directed bench for ff_fifo_with_reg_flags_and_count with a queue-based reference model.
module tb_ff_fifo_with_reg_flags_and_count;

   localparam int W  = 8;
   localparam int D  = 10;
   localparam int AF = 8;
   localparam int AE = 2;

   logic         clk = 1'b0;
   logic         rst_n;
   logic         push;
   logic         pop;
   logic [W-1:0] write_data;
   logic [W-1:0] read_data;
   logic         empty;
   logic         full;
   logic         almost_empty;
   logic         almost_full;
   logic [3:0]   count;
`ifdef FIFO_ERR_FLAGS_EN
   logic         overflow;
   logic         underflow;
`endif

   int   total = 0;
   int   bad   = 0;
   bit   chk_en = 1'b0;
   logic [7:0] mq[$];
   bit   m_ovf = 1'b0;
   bit   m_unf = 1'b0;

   ff_fifo_with_reg_flags_and_count #(
      .width(W), .depth(D), .almost_full_lvl(AF), .almost_empty_lvl(AE)
   ) dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .push         (push),
      .pop          (pop),
      .write_data   (write_data),
      .read_data    (read_data),
      .empty        (empty),
      .full         (full),
      .almost_empty (almost_empty),
      .almost_full  (almost_full),
`ifdef FIFO_ERR_FLAGS_EN
      .overflow     (overflow),
      .underflow    (underflow),
`endif
      .count        (count)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input int act, input int exp);
      total++;
      if (act != exp) begin
         bad++;
         $display("FAIL %s actual=%0d required=%0d at %0t", name, act, exp, $time);
      end
   endtask

   // every-cycle comparison against the queue model
   always @(negedge clk) begin
      if (chk_en && rst_n) begin
         chk("m_count", int'(count), mq.size());
         chk("m_empty", int'(empty), int'(mq.size() == 0));
         chk("m_full", int'(full), int'(mq.size() == D));
         chk("m_almost_empty", int'(almost_empty), int'(mq.size() <= AE));
         chk("m_almost_full", int'(almost_full), int'(mq.size() >= AF));
         if (mq.size() > 0) begin
            chk("m_read_data", int'(read_data), int'(mq[0]));
         end
`ifdef FIFO_ERR_FLAGS_EN
         chk("m_overflow", int'(overflow), int'(m_ovf));
         chk("m_underflow", int'(underflow), int'(m_unf));
`endif
      end
   end

   task automatic step(input bit p, input bit q, input logic [7:0] d);
      int  n;
      bit  pok;
      bit  qok;
      push       = p;
      pop        = q;
      write_data = d;
      @(posedge clk);
      if (rst_n) begin
         n   = mq.size();
         pok = p && ((n < D) || q);
         qok = q && (n > 0);
         if (p && !pok) m_ovf = 1'b1;
         if (q && !qok) m_unf = 1'b1;
         if (qok) void'(mq.pop_front());
         if (pok) mq.push_back(d);
      end
      #1;
   endtask

   initial begin
      rst_n      = 1'b0;
      push       = 1'b0;
      pop        = 1'b0;
      write_data = 8'h00;
      repeat (2) @(posedge clk);
      #3 rst_n = 1'b1;
      @(posedge clk);
      #1;

      // reset state
      chk("rst_empty", int'(empty), 1);
      chk("rst_almost_empty", int'(almost_empty), 1);
      chk("rst_full", int'(full), 0);
      chk("rst_almost_full", int'(almost_full), 0);
      chk("rst_count", int'(count), 0);
      chk_en = 1'b1;

      // fill with 0x01..0x0A
      for (int k = 1; k <= 10; k++) begin
         step(1'b1, 1'b0, 8'(k));
         chk("fill_count", int'(count), k);
         if (k == 2) chk("fill_ae_held", int'(almost_empty), 1);
         if (k == 3) chk("fill_ae_drop", int'(almost_empty), 0);
         if (k == 7) chk("fill_af_low", int'(almost_full), 0);
         if (k == 8) chk("fill_af_rise", int'(almost_full), 1);
         if (k == 9) chk("fill_not_full", int'(full), 0);
         if (k == 10) chk("fill_full", int'(full), 1);
      end

      // push alone while full is dropped
      step(1'b1, 1'b0, 8'hFF);
      chk("ovf_count", int'(count), 10);
      chk("ovf_head", int'(read_data), 32'h01);
`ifdef FIFO_ERR_FLAGS_EN
      chk("ovf_flag", int'(overflow), 1);
`endif

      // push+pop while full
      step(1'b1, 1'b1, 8'hAA);
      chk("pp_full_count", int'(count), 10);
      chk("pp_full_full", int'(full), 1);
      chk("pp_full_head", int'(read_data), 32'h02);

      // drain: 0x02..0x0A then 0xAA
      for (int j = 0; j < 10; j++) begin
         chk("drain_data", int'(read_data), (j == 9) ? 32'hAA : 32'h02 + j);
         step(1'b0, 1'b1, 8'h00);
      end
      chk("drain_count", int'(count), 0);
      chk("drain_empty", int'(empty), 1);

      // pop while empty is ignored
      step(1'b0, 1'b1, 8'h00);
      chk("unf_count", int'(count), 0);
      chk("unf_empty", int'(empty), 1);
`ifdef FIFO_ERR_FLAGS_EN
      chk("unf_flag", int'(underflow), 1);
`endif

      // push+pop while empty: push wins, pop ignored
      step(1'b1, 1'b1, 8'h33);
      chk("pp_empty_count", int'(count), 1);
      chk("pp_empty_head", int'(read_data), 32'h33);
      step(1'b0, 1'b1, 8'h00);

      // streaming at count=3 across pointer wrap
      step(1'b1, 1'b0, 8'h10);
      step(1'b1, 1'b0, 8'h11);
      step(1'b1, 1'b0, 8'h12);
      for (int i = 0; i < 25; i++) begin
         step(1'b1, 1'b1, 8'h20 + 8'(i));
         chk("stream_count", int'(count), 3);
      end
      chk("stream_head", int'(read_data), 32'h36);

      // asynchronous reset in the middle of a burst
      step(1'b1, 1'b1, 8'h55);
      #2 rst_n = 1'b0;
      mq.delete();
      m_ovf = 1'b0;
      m_unf = 1'b0;
      #1;
      chk("arst_count", int'(count), 0);
      chk("arst_empty", int'(empty), 1);
      chk("arst_full", int'(full), 0);
      chk("arst_almost_empty", int'(almost_empty), 1);
`ifdef FIFO_ERR_FLAGS_EN
      chk("arst_overflow", int'(overflow), 0);
      chk("arst_underflow", int'(underflow), 0);
`endif
      push = 1'b0;
      pop  = 1'b0;
      @(posedge clk);
      #3 rst_n = 1'b1;
      @(posedge clk);
      #1;

      step(1'b1, 1'b0, 8'h5A);
      chk("post_rst_head", int'(read_data), 32'h5A);
      chk("post_rst_count", int'(count), 1);
      step(1'b0, 1'b0, 8'h00);

      chk_en = 1'b0;
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
